ad_ip_jesd204_tpl_dac_datasrc: RTL and testbench



---
 rtl/ad_ip_jesd204_tpl_dac_pkg.sv | 30 +++
 rtl/ad_ip_jesd204_tpl_dac_datasrc_if.sv | 23 ++
 rtl/ad_ip_jesd204_tpl_dac_pn.sv | 44 ++++
 rtl/ad_ip_jesd204_tpl_dac_datasrc.sv | 124 ++++++++++++
 tb/tb_ad_ip_jesd204_tpl_dac_datasrc.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ad_ip_jesd204_tpl_dac_pkg.sv
// Shared select codes and PN generator constants for the JESD204 TPL DAC
// sample-source path.
package ad_ip_jesd204_tpl_dac_pkg;

  typedef enum logic [3:0] {
    DAC_SEL_DDS  = 4'd0,
    DAC_SEL_PAT  = 4'd1,
    DAC_SEL_DMA  = 4'd2,
    DAC_SEL_ZERO = 4'd3,
    DAC_SEL_PN7  = 4'd4,
    DAC_SEL_PN15 = 4'd5,
    DAC_SEL_RAMP = 4'd10
  } dac_sel_t;

  localparam logic [15:0] PN_SEED = 16'hFFFF;

  // b[n] = b[n-TAP] ^ b[n-ORDER]
  localparam int unsigned PN7_ORDER  = 7;
  localparam int unsigned PN7_TAP    = 6;
  localparam int unsigned PN15_ORDER = 15;
  localparam int unsigned PN15_TAP   = 14;

  // True on the cycle the select register is about to move into 'code'.
  function automatic logic sel_restarts(input logic [3:0] sel_next,
                                        input logic [3:0] sel_cur,
                                        input dac_sel_t   code);
    return (sel_next == code) && (sel_cur != code);
  endfunction

endpackage

// File: rtl/ad_ip_jesd204_tpl_dac_datasrc_if.sv
// DMA sample stream between the DMA FIFO (master) and the DAC data source (slave).
interface ad_ip_jesd204_tpl_dac_datasrc_if #(
  parameter int DATA_PATH_WIDTH = 4,
  parameter int SAMPLE_WIDTH    = 16
);

  logic [DATA_PATH_WIDTH*SAMPLE_WIDTH-1:0] dma_data;
  logic                                    dma_valid;
  logic                                    dma_ready;

  modport master (
    output dma_data,
    output dma_valid,
    input  dma_ready
  );

  modport slave (
    input  dma_data,
    input  dma_valid,
    output dma_ready
  );

endinterface

// File: rtl/ad_ip_jesd204_tpl_dac_pn.sv
// Parallel Fibonacci LFSR: emits WIDTH sequence bits per advance, earliest bit in pn_bits[0].
module ad_ip_jesd204_tpl_dac_pn
  import ad_ip_jesd204_tpl_dac_pkg::*;
#(
  parameter int unsigned ORDER = 7,
  parameter int unsigned TAP   = 6,
  parameter int unsigned WIDTH = 64
) (
  input  logic             link_clk,
  input  logic             link_resetn,
  input  logic             restart,
  input  logic             advance,
  output logic [WIDTH-1:0] pn_bits
);

  // state_p0[i] holds the sequence bit that will be emitted i positions from now
  logic [ORDER-1:0]       state_p0;
  logic [WIDTH+ORDER-1:0] ext;

  function automatic logic [WIDTH+ORDER-1:0] pn_extend(input logic [ORDER-1:0] head);
    logic [WIDTH+ORDER-1:0] e;
    e            = '0;
    e[ORDER-1:0] = head;
    for (int i = ORDER; i < WIDTH + ORDER; i++) begin
      e[i] = e[i-TAP] ^ e[i-ORDER];
    end
    return e;
  endfunction

  assign ext     = pn_extend(state_p0);
  assign pn_bits = ext[WIDTH-1:0];

  // Stage 0: sequence state
  always_ff @(posedge link_clk or negedge link_resetn) begin
    if (!link_resetn) begin
      state_p0 <= PN_SEED[ORDER-1:0];
    end else if (restart) begin
      state_p0 <= PN_SEED[ORDER-1:0];
    end else if (advance) begin
      state_p0 <= ext[WIDTH +: ORDER];
    end
  end

endmodule

// File: rtl/ad_ip_jesd204_tpl_dac_datasrc.sv
// Per-channel DAC sample source: selects DDS, pattern, DMA, PN7/PN15, ramp or
// zero into the registered channel sample word and flags DMA underflow.
module ad_ip_jesd204_tpl_dac_datasrc
  import ad_ip_jesd204_tpl_dac_pkg::*;
#(
  parameter int DATA_PATH_WIDTH = 4,
  parameter int SAMPLE_WIDTH    = 16
) (
  input  logic                                    link_clk,
  input  logic                                    link_resetn,
  input  logic                                    dac_sync,
  input  logic [3:0]                              dac_data_sel,
  input  logic [SAMPLE_WIDTH-1:0]                 dac_pat_data_0,
  input  logic [SAMPLE_WIDTH-1:0]                 dac_pat_data_1,
  input  logic [DATA_PATH_WIDTH*SAMPLE_WIDTH-1:0] dds_data,
  ad_ip_jesd204_tpl_dac_datasrc_if.slave          dma,
  output logic [DATA_PATH_WIDTH*SAMPLE_WIDTH-1:0] dac_data,
  output logic                                    dac_dunf
);

  localparam int DW = DATA_PATH_WIDTH * SAMPLE_WIDTH;
  localparam logic [SAMPLE_WIDTH-1:0] RAMP_STEP = SAMPLE_WIDTH'(DATA_PATH_WIDTH);

  logic [3:0]              sel_p0;
  logic [SAMPLE_WIDTH-1:0] ramp_base_p0;
  logic [DW-1:0]           pn7_bits;
  logic [DW-1:0]           pn15_bits;
  logic [DW-1:0]           mux_p0;
  logic                    dunf_p0;
  logic                    ramp_restart;
  logic                    pn7_restart;
  logic                    pn15_restart;

  // Sequence bit 16k is the MSB of sample k.
  function automatic logic [DW-1:0] pn_to_samples(input logic [DW-1:0] bits);
    logic [DW-1:0] s;
    s = '0;
    for (int k = 0; k < DATA_PATH_WIDTH; k++) begin
      for (int j = 0; j < SAMPLE_WIDTH; j++) begin
        s[k*SAMPLE_WIDTH+j] = bits[k*SAMPLE_WIDTH+SAMPLE_WIDTH-1-j];
      end
    end
    return s;
  endfunction

  assign ramp_restart = dac_sync || sel_restarts(dac_data_sel, sel_p0, DAC_SEL_RAMP);
  assign pn7_restart  = dac_sync || sel_restarts(dac_data_sel, sel_p0, DAC_SEL_PN7);
  assign pn15_restart = dac_sync || sel_restarts(dac_data_sel, sel_p0, DAC_SEL_PN15);

  assign dma.dma_ready = (sel_p0 == DAC_SEL_DMA);
  assign dunf_p0       = dma.dma_ready && !dma.dma_valid;

  ad_ip_jesd204_tpl_dac_pn #(
    .ORDER (PN7_ORDER),
    .TAP   (PN7_TAP),
    .WIDTH (DW)
  ) i_pn7 (
    .link_clk    (link_clk),
    .link_resetn (link_resetn),
    .restart     (pn7_restart),
    .advance     (sel_p0 == DAC_SEL_PN7),
    .pn_bits     (pn7_bits)
  );

  ad_ip_jesd204_tpl_dac_pn #(
    .ORDER (PN15_ORDER),
    .TAP   (PN15_TAP),
    .WIDTH (DW)
  ) i_pn15 (
    .link_clk    (link_clk),
    .link_resetn (link_resetn),
    .restart     (pn15_restart),
    .advance     (sel_p0 == DAC_SEL_PN15),
    .pn_bits     (pn15_bits)
  );

  always_comb begin
    mux_p0 = '0;
    case (sel_p0)
      DAC_SEL_DDS: mux_p0 = dds_data;
      DAC_SEL_PAT: begin
        for (int k = 0; k < DATA_PATH_WIDTH; k++) begin
          mux_p0[k*SAMPLE_WIDTH +: SAMPLE_WIDTH] = ((k & 1) != 0) ? dac_pat_data_1 : dac_pat_data_0;
        end
      end
      DAC_SEL_DMA:  mux_p0 = dunf_p0 ? '0 : dma.dma_data;
      DAC_SEL_PN7:  mux_p0 = pn_to_samples(pn7_bits);
      DAC_SEL_PN15: mux_p0 = pn_to_samples(pn15_bits);
      DAC_SEL_RAMP: begin
        for (int k = 0; k < DATA_PATH_WIDTH; k++) begin
          mux_p0[k*SAMPLE_WIDTH +: SAMPLE_WIDTH] = ramp_base_p0 + SAMPLE_WIDTH'(k);
        end
      end
      default: mux_p0 = '0;
    endcase
  end

  // Stage 0: select register and ramp base
  always_ff @(posedge link_clk or negedge link_resetn) begin
    if (!link_resetn) begin
      sel_p0       <= DAC_SEL_ZERO;
      ramp_base_p0 <= '0;
    end else begin
      sel_p0 <= dac_data_sel;
      if (ramp_restart) begin
        ramp_base_p0 <= '0;
      end else if (sel_p0 == DAC_SEL_RAMP) begin
        ramp_base_p0 <= ramp_base_p0 + RAMP_STEP;
      end
    end
  end

  // Stage 1: registered sample word and underflow flag
  always_ff @(posedge link_clk or negedge link_resetn) begin
    if (!link_resetn) begin
      dac_data <= '0;
      dac_dunf <= 1'b0;
    end else begin
      dac_data <= mux_p0;
      dac_dunf <= dunf_p0;
    end
  end

endmodule

// File: tb/tb_ad_ip_jesd204_tpl_dac_datasrc.sv
// Directed bench for the DAC sample source: reset, ramp, pattern, PN7/PN15, DDS, DMA and underflow.
module tb_ad_ip_jesd204_tpl_dac_datasrc;

  logic        link_clk = 1'b0;
  logic        link_resetn;
  logic        dac_sync;
  logic [3:0]  dac_data_sel;
  logic [15:0] dac_pat_data_0;
  logic [15:0] dac_pat_data_1;
  logic [63:0] dds_data;
  logic [63:0] dac_data;
  logic        dac_dunf;

  int n_vec = 0;
  int n_err = 0;

  logic [15:0] m_sr;
  int          m_order;
  int          m_tap;
  logic [63:0] exp_w;

  ad_ip_jesd204_tpl_dac_datasrc_if #(.DATA_PATH_WIDTH(4), .SAMPLE_WIDTH(16)) dma_if ();

  ad_ip_jesd204_tpl_dac_datasrc #(
    .DATA_PATH_WIDTH (4),
    .SAMPLE_WIDTH    (16)
  ) dut (
    .link_clk       (link_clk),
    .link_resetn    (link_resetn),
    .dac_sync       (dac_sync),
    .dac_data_sel   (dac_data_sel),
    .dac_pat_data_0 (dac_pat_data_0),
    .dac_pat_data_1 (dac_pat_data_1),
    .dds_data       (dds_data),
    .dma            (dma_if.slave),
    .dac_data       (dac_data),
    .dac_dunf       (dac_dunf)
  );

  always #5 link_clk = ~link_clk;

  task automatic check_vec(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge link_clk);
    #1;
  endtask

  task automatic pn_model_init(input int order, input int tap);
    m_sr    = 16'hFFFF;
    m_order = order;
    m_tap   = tap;
  endtask

  // Bit-serial reference: m_sr[m_order-1] is the next bit to be emitted.
  task automatic pn_model_word(output logic [63:0] w);
    logic nb;
    w = '0;
    for (int k = 0; k < 4; k++) begin
      for (int j = 15; j >= 0; j--) begin
        w[k*16+j] = m_sr[m_order-1];
        nb        = m_sr[m_tap-1] ^ m_sr[m_order-1];
        m_sr      = {m_sr[14:0], nb};
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    link_resetn       = 1'b0;
    dac_sync          = 1'b0;
    dac_data_sel      = 4'd3;
    dac_pat_data_0    = 16'h0;
    dac_pat_data_1    = 16'h0;
    dds_data          = 64'h0;
    dma_if.dma_data   = 64'h0;
    dma_if.dma_valid  = 1'b1;

    repeat (3) tick();
    check_vec("rst_data", dac_data, 64'h0);
    check_vec("rst_ready", {63'h0, dma_if.dma_ready}, 64'h0);
    check_vec("rst_dunf", {63'h0, dac_dunf}, 64'h0);
    link_resetn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_vec("zero_data", dac_data, 64'h0);
      check_vec("zero_ready", {63'h0, dma_if.dma_ready}, 64'h0);
      check_vec("zero_dunf", {63'h0, dac_dunf}, 64'h0);
    end
    dma_if.dma_valid = 1'b0;

    // ramp
    dac_data_sel = 4'd10;
    dac_sync     = 1'b1;
    tick();
    dac_sync = 1'b0;
    tick();
    check_vec("ramp_w0", dac_data, 64'h0003_0002_0001_0000);
    tick();
    check_vec("ramp_w1", dac_data, 64'h0007_0006_0005_0004);
    dac_sync = 1'b1;
    tick();
    check_vec("ramp_w2", dac_data, 64'h000B_000A_0009_0008);
    dac_sync = 1'b0;
    tick();
    check_vec("ramp_sync", dac_data, 64'h0003_0002_0001_0000);
    repeat (16382) tick();
    tick();
    check_vec("ramp_top", dac_data, 64'hFFFF_FFFE_FFFD_FFFC);
    tick();
    check_vec("ramp_wrap", dac_data, 64'h0003_0002_0001_0000);

    // pattern
    dac_data_sel   = 4'd1;
    dac_pat_data_0 = 16'h1234;
    dac_pat_data_1 = 16'hABCD;
    tick();
    tick();
    check_vec("pat_w0", dac_data, 64'hABCD_1234_ABCD_1234);
    dac_sync = 1'b1;
    tick();
    check_vec("pat_sync", dac_data, 64'hABCD_1234_ABCD_1234);
    dac_sync = 1'b0;
    tick();
    check_vec("pat_w2", dac_data, 64'hABCD_1234_ABCD_1234);

    // asynchronous reset, then PN7 from reset
    link_resetn = 1'b0;
    #2;
    check_vec("rst_async_data", dac_data, 64'h0);
    dac_data_sel = 4'd4;
    tick();
    link_resetn = 1'b1;
    tick();
    check_vec("pn7_first_zero", dac_data, 64'h0);
    pn_model_init(7, 6);
    tick();
    check_vec("pn7_s0", {48'h0, dac_data[15:0]}, 64'hFE04);
    pn_model_word(exp_w);
    check_vec("pn7_w0", dac_data, exp_w);
    for (int i = 0; i < 126; i++) begin
      tick();
      pn_model_word(exp_w);
      check_vec("pn7_stream", dac_data, exp_w);
    end
    dac_sync = 1'b1;
    tick();
    pn_model_word(exp_w);
    check_vec("pn7_pre_sync", dac_data, exp_w);
    dac_sync = 1'b0;
    pn_model_init(7, 6);
    tick();
    check_vec("pn7_sync_s0", {48'h0, dac_data[15:0]}, 64'hFE04);
    pn_model_word(exp_w);
    check_vec("pn7_sync_w", dac_data, exp_w);

    // PN15
    dac_data_sel = 4'd5;
    tick();
    pn_model_init(15, 14);
    tick();
    check_vec("pn15_s0", {48'h0, dac_data[15:0]}, 64'hFFFE);
    check_vec("pn15_s1", {48'h0, dac_data[31:16]}, 64'h0004);
    pn_model_word(exp_w);
    check_vec("pn15_w0", dac_data, exp_w);
    for (int i = 0; i < 8; i++) begin
      tick();
      pn_model_word(exp_w);
      check_vec("pn15_stream", dac_data, exp_w);
    end

    // DDS passthrough, one cycle latency on data
    dac_data_sel = 4'd0;
    dds_data     = 64'h1111_2222_3333_4444;
    tick();
    dds_data = 64'h5555_6666_7777_8888;
    tick();
    check_vec("dds_w0", dac_data, 64'h5555_6666_7777_8888);
    dds_data = 64'h9999_AAAA_BBBB_CCCC;
    tick();
    check_vec("dds_w1", dac_data, 64'h9999_AAAA_BBBB_CCCC);

    // DMA and underflow
    dds_data         = 64'hDEAD_BEEF_0BAD_F00D;
    dac_data_sel     = 4'd2;
    dma_if.dma_valid = 1'b1;
    dma_if.dma_data  = 64'h0001_0002_0003_0004;
    tick();
    check_vec("sel_latency", dac_data, 64'hDEAD_BEEF_0BAD_F00D);
    check_vec("dma_ready_up", {63'h0, dma_if.dma_ready}, 64'h1);
    tick();
    check_vec("dma_w0", dac_data, 64'h0001_0002_0003_0004);
    check_vec("dma_w0_dunf", {63'h0, dac_dunf}, 64'h0);
    dma_if.dma_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_vec("dunf_data", dac_data, 64'h0);
      check_vec("dunf_flag", {63'h0, dac_dunf}, 64'h1);
    end
    dma_if.dma_valid = 1'b1;
    dma_if.dma_data  = 64'h0005_0006_0007_0008;
    tick();
    check_vec("dma_w1", dac_data, 64'h0005_0006_0007_0008);
    check_vec("dma_w1_dunf", {63'h0, dac_dunf}, 64'h0);

    // leave DMA while starved
    dma_if.dma_valid = 1'b0;
    dac_data_sel     = 4'd0;
    dds_data         = 64'h0A0B_0C0D_0102_0304;
    tick();
    check_vec("leave_last_dunf", {63'h0, dac_dunf}, 64'h1);
    check_vec("leave_ready", {63'h0, dma_if.dma_ready}, 64'h0);
    tick();
    check_vec("leave_no_dunf", {63'h0, dac_dunf}, 64'h0);
    check_vec("leave_dds", dac_data, 64'h0A0B_0C0D_0102_0304);

    // reset in the middle of DMA traffic
    dac_data_sel     = 4'd2;
    dma_if.dma_valid = 1'b1;
    dma_if.dma_data  = 64'h1357_9BDF_2468_ACE0;
    tick();
    tick();
    check_vec("dma_pre_rst", dac_data, 64'h1357_9BDF_2468_ACE0);
    link_resetn = 1'b0;
    #2;
    check_vec("rst_mid_data", dac_data, 64'h0);
    check_vec("rst_mid_ready", {63'h0, dma_if.dma_ready}, 64'h0);
    check_vec("rst_mid_dunf", {63'h0, dac_dunf}, 64'h0);
    tick();
    link_resetn = 1'b1;
    tick();
    check_vec("rst_first_out", dac_data, 64'h0);
    check_vec("rst_ready_back", {63'h0, dma_if.dma_ready}, 64'h1);
    tick();
    check_vec("dma_after_rst", dac_data, 64'h1357_9BDF_2468_ACE0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
